// File: rtl/count_ctrl_if.sv
// Pushbutton-side bundle between the button front end and count_ctrl.
// The slave side is the control stage; the master side drives raw buttons.
interface count_ctrl_if;
    logic step_btn;
    logic dir_btn;
    logic auto_en;
    logic count;
    logic inc;
    logic mode;

    modport master (
        output step_btn,
        output dir_btn,
        output auto_en,
        input  count,
        input  inc,
        input  mode
    );

    modport slave (
        input  step_btn,
        input  dir_btn,
        input  auto_en,
        output count,
        output inc,
        output mode
    );
endinterface

// File: rtl/count_ctrl.sv
// Button front end for the 3-bit up/down counter: synchronise, debounce and
// edge-detect the step/dir buttons, and generate periodic steps in auto mode.
module count_ctrl #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DB_W      = 3,
    parameter int unsigned AUTO_DIV  = 8,
    parameter int unsigned DIV_W     = 4
) (
    input logic         clk,
    input logic         set,
    count_ctrl_if.slave bus
);

    typedef enum logic [0:0] {StManual, StAuto} mode_e;

    localparam logic [DB_W-1:0]  DbLast  = DB_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DivLast = DIV_W'(AUTO_DIV - 1);

    // Bit 0 is the step button, bit 1 the direction button.
    logic [1:0]           btn_raw;
    logic [1:0]           btn_s1_q;
    logic [1:0]           btn_s2_q;
    logic [1:0]           stable_q;
    logic [1:0]           stable_d;
    logic [1:0]           dly_q;
    logic [1:0][DB_W-1:0] db_cnt_q;
    logic [1:0][DB_W-1:0] db_cnt_d;

    logic                 auto_s1_q;
    logic                 auto_s2_q;
    mode_e                state_q;
    mode_e                state_d;
    logic [DIV_W-1:0]     presc_q;
    logic [DIV_W-1:0]     presc_d;
    logic                 count_q;
    logic                 count_d;
    logic                 inc_q;
    logic                 inc_d;
    logic                 step_evt;
    logic                 dir_evt;

    assign btn_raw  = {bus.dir_btn, bus.step_btn};
    assign step_evt = stable_q[0] & ~dly_q[0];
    assign dir_evt  = stable_q[1] & ~dly_q[1];

    // A differing sample only flips the stable state once it has persisted
    // DB_CYCLES consecutive cycles; any agreeing sample restarts the count.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (btn_s2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    stable_d[i] = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        count_d = 1'b0;
        inc_d   = inc_q ^ dir_evt;
        case (state_q)
            StManual: begin
                count_d = step_evt;
                if (auto_s2_q) begin
                    state_d = StAuto;
                end
            end
            StAuto: begin
                // Leaving auto clears the prescaler and suppresses any pulse.
                if (!auto_s2_q) begin
                    state_d = StManual;
                end else if (presc_q == DivLast) begin
                    count_d = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = StManual;
        endcase
    end

    always_ff @(posedge clk) begin
        if (set) begin
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            stable_q  <= '0;
            dly_q     <= '0;
            db_cnt_q  <= '0;
            auto_s1_q <= 1'b0;
            auto_s2_q <= 1'b0;
            state_q   <= StManual;
            presc_q   <= '0;
            count_q   <= 1'b0;
            inc_q     <= 1'b1;
        end else begin
            btn_s1_q  <= btn_raw;
            btn_s2_q  <= btn_s1_q;
            stable_q  <= stable_d;
            dly_q     <= stable_q;
            db_cnt_q  <= db_cnt_d;
            auto_s1_q <= bus.auto_en;
            auto_s2_q <= auto_s1_q;
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            inc_q     <= inc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.inc   = inc_q;
    assign bus.mode  = (state_q == StAuto);

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: directed scenarios plus random button
// activity, all compared against a cycle-level behavioural model.
module tb_count_ctrl;

    localparam int unsigned DB_CYCLES = 4;
    localparam int unsigned AUTO_DIV  = 8;

    logic clk = 1'b0;
    logic set;
    int   errors = 0;
    int   checks = 0;

    count_ctrl_if bus ();

    count_ctrl #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (3),
        .AUTO_DIV (AUTO_DIV),
        .DIV_W    (4)
    ) dut (
        .clk(clk),
        .set(set),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: raw samples reach the logic two edges late; a button's accepted
    // level changes after DB_CYCLES consecutive disagreeing samples, and a
    // press is acted on the edge after it is accepted.
    bit m_p1 [3];
    bit m_p2 [3];
    bit m_stab [2];
    bit m_rose [2];
    int m_run [2];
    bit m_mode;
    bit m_count;
    bit m_inc = 1'b1;
    int m_auto_cycles;

    task automatic model_step(input bit setv, input bit st, input bit dr, input bit au);
        bit syn [3];
        bit step_evt;
        bit dir_evt;
        if (setv) begin
            for (int i = 0; i < 3; i++) begin
                m_p1[i] = 1'b0;
                m_p2[i] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                m_stab[i] = 1'b0;
                m_rose[i] = 1'b0;
                m_run[i]  = 0;
            end
            m_mode = 1'b0;
            m_count = 1'b0;
            m_inc = 1'b1;
            m_auto_cycles = 0;
            return;
        end
        syn = m_p2;
        step_evt = m_rose[0];
        dir_evt = m_rose[1];
        if (!m_mode) m_count = step_evt;
        else m_count = syn[2] && (((m_auto_cycles + 1) % AUTO_DIV) == 0);
        if (!m_mode) begin
            if (syn[2]) begin
                m_mode = 1'b1;
                m_auto_cycles = 0;
            end
        end else if (syn[2]) begin
            m_auto_cycles++;
        end else begin
            m_mode = 1'b0;
        end
        m_inc ^= dir_evt;
        for (int i = 0; i < 2; i++) begin
            m_rose[i] = 1'b0;
            if (syn[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DB_CYCLES) begin
                    m_stab[i] = syn[i];
                    m_run[i] = 0;
                    m_rose[i] = syn[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_p2 = m_p1;
        m_p1[0] = st;
        m_p1[1] = dr;
        m_p1[2] = au;
    endtask

    task automatic tick(input bit setv, input bit st, input bit dr, input bit au);
        set = setv;
        bus.step_btn = st;
        bus.dir_btn = dr;
        bus.auto_en = au;
        @(posedge clk);
        model_step(setv, st, dr, au);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.count !== m_count || bus.inc !== m_inc || bus.mode !== m_mode) begin
                errors++;
                $display("FAIL settle: count/inc/mode=%b%b%b expected %b%b%b at %0t",
                         bus.count, bus.inc, bus.mode, m_count, m_inc, m_mode, $time);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, i[0], ~i[0], i[0]);
            checks++;
            if (bus.count !== 1'b0 || bus.inc !== 1'b1 || bus.mode !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: count/inc/mode=%b%b%b expected 010",
                         bus.count, bus.inc, bus.mode);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 1'b0 || bus.inc !== 1'b1 || bus.mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: count/inc/mode=%b%b%b expected 010",
                     bus.count, bus.inc, bus.mode);
        end
    endtask

    task automatic test_step_clean();
        int pulses = 0;
        int first = 0;
        int late = 0;
        settle(12);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.count !== m_count || bus.inc !== m_inc || bus.mode !== m_mode) begin
                errors++;
                $display("FAIL step_clean: count/inc/mode=%b%b%b expected %b%b%b edge %0d",
                         bus.count, bus.inc, bus.mode, m_count, m_inc, m_mode, i);
            end
            if (bus.count === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (pulses != 1 || first != DB_CYCLES + 3) begin
            errors++;
            $display("FAIL step_latency: pulses=%0d first_edge=%0d expected 1 at %0d",
                     pulses, first, DB_CYCLES + 3);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.count === 1'b1) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL step_release: pulses=%0d expected 0", late);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        settle(12);
        for (int len = 3; len <= 4; len++) begin
            pulses = 0;
            for (int i = 0; i < len + 12; i++) begin
                tick(1'b0, (i < len), 1'b0, 1'b0);
                checks++;
                if (bus.count !== m_count) begin
                    errors++;
                    $display("FAIL glitch_model: count=%b expected %b len %0d cycle %0d",
                             bus.count, m_count, len, i);
                end
                if (bus.count === 1'b1) pulses++;
            end
            checks++;
            if (pulses != ((len >= DB_CYCLES) ? 1 : 0)) begin
                errors++;
                $display("FAIL glitch_len%0d: pulses=%0d expected %0d", len, pulses,
                         (len >= DB_CYCLES) ? 1 : 0);
            end
        end
    endtask

    task automatic test_dir();
        bit inc0;
        bit exp_inc;
        int pulses = 0;
        settle(12);
        inc0 = m_inc;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            exp_inc = (i >= DB_CYCLES + 3) ? ~inc0 : inc0;
            checks++;
            if (bus.inc !== exp_inc || bus.count !== 1'b0) begin
                errors++;
                $display("FAIL dir_toggle: inc=%b count=%b expected inc=%b count=0 edge %0d",
                         bus.inc, bus.count, exp_inc, i);
            end
        end
        settle(8);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 14; i++) begin
                tick(1'b0, (i < 6), 1'b0, 1'b0);
                checks++;
                if (bus.count !== m_count || bus.inc !== ~inc0) begin
                    errors++;
                    $display("FAIL dir_steps: count=%b inc=%b expected %b %b",
                             bus.count, bus.inc, m_count, ~inc0);
                end
                if (bus.count === 1'b1) pulses++;
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL dir_step_count: pulses=%0d expected 3", pulses);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
        settle(8);
        checks++;
        if (bus.inc !== inc0) begin
            errors++;
            $display("FAIL dir_second: inc=%b expected %b", bus.inc, inc0);
        end
    endtask

    task automatic test_auto();
        int pe[$];
        int rise = 0;
        int fall = 0;
        int bad_gap = 0;
        settle(12);
        for (int i = 1; i <= 54; i++) begin
            tick(1'b0, (i >= 15 && i <= 25), 1'b0, (i <= 42));
            checks++;
            if (bus.count !== m_count || bus.inc !== m_inc || bus.mode !== m_mode) begin
                errors++;
                $display("FAIL auto_model: count/inc/mode=%b%b%b expected %b%b%b edge %0d",
                         bus.count, bus.inc, bus.mode, m_count, m_inc, m_mode, i);
            end
            if (bus.count === 1'b1) pe.push_back(i);
            if (bus.mode === 1'b1 && rise == 0) rise = i;
            if (bus.mode === 1'b0 && rise != 0 && fall == 0) fall = i;
        end
        checks++;
        if (rise != 3 || fall != 45) begin
            errors++;
            $display("FAIL auto_mode: rise=%0d fall=%0d expected 3 and 45", rise, fall);
        end
        checks++;
        if (pe.size() != 5) begin
            errors++;
            $display("FAIL auto_pulses: count=%0d expected 5", pe.size());
        end else begin
            for (int k = 1; k < 5; k++) if (pe[k] - pe[k-1] != AUTO_DIV) bad_gap++;
            checks++;
            if (pe[0] != 3 + AUTO_DIV || bad_gap != 0) begin
                errors++;
                $display("FAIL auto_spacing: first=%0d bad_gaps=%0d expected %0d and 0",
                         pe[0], bad_gap, 3 + AUTO_DIV);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int first = 0;
        settle(12);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, (i < 2), 1'b0, 1'b0);
            checks++;
            if (bus.count !== m_count) begin
                errors++;
                $display("FAIL reset_db_model: count=%b expected %b", bus.count, m_count);
            end
            if (bus.count === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_db: pulses=%0d expected 0", pulses);
        end
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (bus.count !== m_count || bus.mode !== m_mode) begin
                errors++;
                $display("FAIL reset_presc_model: count/mode=%b%b expected %b%b",
                         bus.count, bus.mode, m_count, m_mode);
            end
            if (bus.count === 1'b1 && first == 0) first = i;
        end
        checks++;
        if (first != 3 + AUTO_DIV) begin
            errors++;
            $display("FAIL reset_presc: first pulse edge=%0d expected %0d", first, 3 + AUTO_DIV);
        end
        settle(12);
    endtask

    task automatic test_simultaneous();
        bit inc0;
        int inc_edge = 0;
        bit cnt_at = 1'b0;
        settle(12);
        inc0 = m_inc;
        for (int i = 1; i <= 24; i++) begin
            tick(1'b0, 1'b0, (i >= 13 && i <= 22), 1'b1);
            checks++;
            if (bus.count !== m_count || bus.inc !== m_inc || bus.mode !== m_mode) begin
                errors++;
                $display("FAIL simul_model: count/inc/mode=%b%b%b expected %b%b%b edge %0d",
                         bus.count, bus.inc, bus.mode, m_count, m_inc, m_mode, i);
            end
            if (bus.inc !== inc0 && inc_edge == 0) begin
                inc_edge = i;
                cnt_at = bus.count;
            end
        end
        checks++;
        if (inc_edge != 19 || cnt_at !== 1'b1) begin
            errors++;
            $display("FAIL simul_edge: inc changed at %0d with count=%b expected 19 with 1",
                     inc_edge, cnt_at);
        end
        settle(12);
    endtask

    task automatic test_random();
        bit st = 1'b0;
        bit dr = 1'b0;
        bit au = 1'b0;
        int hs = 0;
        int hd = 0;
        int ha = 0;
        bit prev = 1'b0;
        bit rst;
        for (int i = 0; i < 1500; i++) begin
            if (hs == 0) begin st = $urandom_range(0, 1); hs = $urandom_range(1, 10); end
            if (hd == 0) begin dr = $urandom_range(0, 1); hd = $urandom_range(1, 10); end
            if (ha == 0) begin au = $urandom_range(0, 1); ha = $urandom_range(4, 40); end
            hs--;
            hd--;
            ha--;
            rst = ($urandom_range(0, 99) == 0);
            tick(rst, st, dr, au);
            checks++;
            if (bus.count !== m_count || bus.inc !== m_inc || bus.mode !== m_mode) begin
                errors++;
                $display("FAIL random: count/inc/mode=%b%b%b expected %b%b%b cycle %0d",
                         bus.count, bus.inc, bus.mode, m_count, m_inc, m_mode, i);
            end
            checks++;
            if (prev === 1'b1 && bus.count === 1'b1) begin
                errors++;
                $display("FAIL random_double: count=1 on consecutive cycles, expected 0 at %0d", i);
            end
            prev = bus.count;
        end
        settle(12);
    endtask

    initial begin
        set = 1'b1;
        bus.step_btn = 1'b0;
        bus.dir_btn = 1'b0;
        bus.auto_en = 1'b0;
        test_reset();
        test_step_clean();
        test_glitch();
        test_dir();
        test_auto();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Upstream control stage for the 3-bit synchronous up/down counter. It converts raw pushbutton inputs into the counter's `count` (step enable) and `inc` (direction) controls. Each button is synchronised, debounced and edge-detected. The block also has an auto-step mode that issues periodic single-cycle `count` pulses from a prescaler. Its outputs connect directly to the counter's `count` and `inc` inputs, and the block shares `clk` and `set` with the counter.

Parameters:
- DB_CYCLES, 4, number of consecutive synchronised cycles a button must differ from its debounced state before that state flips (>=2).
- DB_W, 3, width of each debounce counter; must hold DB_CYCLES-1.
- AUTO_DIV, 8, auto-step period in clk cycles (>=2).
- DIV_W, 4, prescaler width; must hold AUTO_DIV-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- set  input  1  synchronous active-high reset.
- step_btn  input  1  raw asynchronous step button.
- dir_btn  input  1  raw asynchronous direction button; each press toggles direction.
- auto_en  input  1  raw asynchronous level; 1 selects auto-step mode.
- count  output  1  registered single-cycle step pulse to the counter.
- inc  output  1  registered direction to the counter; 1 = up, 0 = down.
- mode  output  1  registered current mode; 0 = MANUAL, 1 = AUTO.

Behaviour:

Reset (`set`=1 sampled on a rising edge):
- count=0, inc=1, mode=0.
- All synchroniser flops, debounced states, edge-detect delays, debounce counters and the prescaler are cleared to 0.
- Reset overrides every other event in the same cycle.
- A reset asserted mid-debounce or mid-prescale discards the partial count.

Synchronisers:
- step_btn, dir_btn and auto_en each pass through a 2-flop synchroniser.
- The synchronised value is valid 2 edges after the raw input changes.

Debounce (per button, step and dir):
- The block holds a stable state and a counter per button.
- If the synchronised value equals the stable state, the counter clears.
- Otherwise the counter increments.
- When the counter equals DB_CYCLES-1 and the values still differ, the stable state takes the synchronised value and the counter clears.
- Net effect: a change must persist DB_CYCLES synchronised cycles to be accepted. Shorter glitches are fully rejected.

Edge detect:
- An event fires on the rising edge of a debounced state (stable=1, delayed=0).
- Release (falling edge) generates no event.
- A held button generates exactly one event.

Direction:
- On a dir event, inc toggles at the next edge.

Mode state machine (2 states, driven by synchronised auto_en; no debounce on auto_en):
- MANUAL -> AUTO when auto_en sync=1. Prescaler cleared on entry.
- AUTO -> MANUAL when auto_en sync=0. Prescaler cleared; no pulse is emitted on exit.

count generation:
- MANUAL: count=1 for exactly one cycle, one edge after each step event.
  - Latency from first edge sampling step_btn=1 (held): count asserts after edge DB_CYCLES+3 (edge 7 at defaults).
- AUTO: the prescaler counts 0..AUTO_DIV-1 and wraps.
  - count=1 for one cycle whenever the prescaler wraps, so the first pulse is AUTO_DIV cycles after entry and subsequent pulses are every AUTO_DIV cycles.
  - Manual step events in AUTO are ignored and are not queued.
- count is never high for two consecutive cycles while AUTO_DIV>=2.

Simultaneous events:
- A dir event and a count-generating event in the same cycle update inc and count at the same edge.
- The counter therefore samples the new direction with that step.

Test Plan:
- Reset: hold set=1 for 3 cycles with buttons toggling -> count=0, inc=1, mode=0 throughout; all remain 0/1/0 one cycle after release.
- Clean step press (defaults): step_btn=1 held 20 cycles -> count high for exactly one cycle after edge 7, no further pulses. With downstream counter from q=0, q=1.
- Glitch reject: step_btn=1 for 3 cycles then 0 -> count never asserts. A 4-cycle-synchronised pulse -> exactly one count.
- Direction: dir_btn press -> inc 1->0 at edge 7. Then three step presses -> counter q 0 -> 7 -> 6 -> 5, with cout on the wrap. A second dir press -> inc=1.
- Auto mode: auto_en=1 for 42 cycles at AUTO_DIV=8 -> mode=1 after 2 edges; 5 count pulses exactly 8 cycles apart; step presses during AUTO produce no extra pulses; auto_en=0 -> mode=0, no pulse on exit.
- Reset mid-operation/simultaneity: assert set during a debounce count and mid-prescale -> no pulse, prescaler restarts from 0 on re-entry. A dir event aligned with an auto pulse -> inc and count change at the same edge.
